// File: rtl/sba_pkg.sv
// Shared types and defaults for the serial-decoder field path (decoder -> capture buffer).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sba_pkg;

    // Default widths of the decoder field path.
    localparam int DEPTH_DEF   = 16;
    localparam int DATA_W_DEF  = 32;
    localparam int STATE_W_DEF = 5;
    localparam int LEN_W_DEF   = 6;
    localparam int TS_W_DEF    = 16;

    // Dropped-record counter saturates here instead of wrapping.
    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

    // One decoded field record as stored in and read from the capture buffer.
    typedef struct packed {
        logic [STATE_W_DEF-1:0] state;
        logic [LEN_W_DEF-1:0]   len;
        logic [DATA_W_DEF-1:0]  data;
        logic [TS_W_DEF-1:0]    ts;
        logic                   frame_end;
        logic                   gap;
    } field_rec_t;

    localparam int FIELD_REC_W = $bits(field_rec_t);

endpackage

// File: rtl/sba_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with explicit level tracking.
// Latency: a word written at edge N is visible on rd_data_o after edge N; no empty bypass.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module sba_sync_fifo
    import sba_pkg::*;
#(
    parameter int WIDTH = FIELD_REC_W,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same edge, so a full FIFO can still accept a push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointers and level; pointers are power-of-two wide and wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level state; reset empties the FIFO, stored words become stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/field_capture_buffer.sv
// Timestamps decoded field records, clips/masks them and buffers them for host readout.
// Latency: record accepted at edge N is at the head (out_valid=1) after edge N if the buffer was empty.
// Backpressure: none upstream; when full without a pop the record is dropped, counted and flagged as a gap.
module field_capture_buffer
    import sba_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int STATE_W = STATE_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TS_W    = TS_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [STATE_W-1:0]      in_state,
    input  logic [LEN_W-1:0]        in_len,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_frame_end,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [STATE_W-1:0]      out_state,
    output logic [LEN_W-1:0]        out_len,
    output logic [DATA_W-1:0]       out_data,
    output logic [TS_W-1:0]         out_ts,
    output logic                    out_frame_end,
    output logic                    out_gap,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic [15:0]             drop_cnt
);

    // Same layout as field_rec_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic [LEN_W-1:0]   len;
        logic [DATA_W-1:0]  data;
        logic [TS_W-1:0]    ts;
        logic               frame_end;
        logic               gap;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              gap_pending_q, gap_pending_d;
    logic              fifo_full, fifo_empty;
    logic              push, pop, drop;
    logic [LEN_W-1:0]  len_clip;
    logic [DATA_W-1:0] data_mask;
    rec_t              wr_rec;
    rec_t              rd_rec;

    assign pop  = !fifo_empty && out_ready;
    assign push = in_valid && (!fifo_full || pop);
    assign drop = in_valid && fifo_full && !pop;

    // Clip the length to the data width and zero every bit at or above it.
    always_comb begin
        len_clip  = (in_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : in_len;
        data_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data_mask[i] = in_data[i] && (LEN_W'(i) < len_clip);
        end
    end

    // Pack the record, carrying any pending gap into the next stored entry.
    always_comb begin
        wr_rec           = '0;
        wr_rec.state     = in_state;
        wr_rec.len       = len_clip;
        wr_rec.data      = data_mask;
        wr_rec.ts        = ts_q;
        wr_rec.frame_end = in_frame_end;
        wr_rec.gap       = gap_pending_q;
    end

    // Free-running timestamp, saturating drop counter and gap bookkeeping.
    always_comb begin
        ts_d          = ts_q + TS_W'(1);
        drop_cnt_d    = drop_cnt_q;
        gap_pending_d = gap_pending_q;
        if (drop) begin
            gap_pending_d = 1'b1;
            if (drop_cnt_q != DROP_CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (push) begin
            gap_pending_d = 1'b0;
        end
    end

    // Control state; reset restarts the timestamp and forgets any pending gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q          <= '0;
            drop_cnt_q    <= '0;
            gap_pending_q <= 1'b0;
        end else begin
            ts_q          <= ts_d;
            drop_cnt_q    <= drop_cnt_d;
            gap_pending_q <= gap_pending_d;
        end
    end

    sba_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .wr_data_i (wr_rec),
        .pop_i     (pop),
        .rd_data_o (rd_rec),
        .level_o   (level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign out_valid     = !fifo_empty;
    assign out_state     = rd_rec.state;
    assign out_len       = rd_rec.len;
    assign out_data      = rd_rec.data;
    assign out_ts        = rd_rec.ts;
    assign out_frame_end = rd_rec.frame_end;
    // Gated so a stale array word never reports a gap on an empty buffer.
    assign out_gap       = rd_rec.gap && !fifo_empty;
    assign full          = fifo_full;
    assign drop_cnt      = drop_cnt_q;

endmodule
